bridge_startup_sequencer: RTL and testbench

- Final stage between `dead_time` output `{Q4,Q3,Q2,Q1}` and the H-bridge gate pins `Q[3:0]`.
- Sequences start-up in three steps: bootstrap-capacitor charge (low sides on), then tank precharge (forced sigma=1), then hand-over to the control law.
- Enforces shoot-through protection with a latched fault.
- Replaces the free-running `counter_up` instances and the combinational `Q` gating, with a single-clock, cycle-exact FSM.

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/bridge_startup_sequencer_dwell_timer.sv | 31 +++
 rtl/bridge_startup_sequencer.sv | 174 +++++++++++++++++
 tb/tb_bridge_startup_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared encodings for the H-bridge start-up sequencer: FSM states, fixed gate
// patterns and the bit positions of the two bridge legs.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BOOT      = 3'd1,
        ST_PRECHARGE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam logic [3:0] Q_OFF       = 4'b0000;
    localparam logic [3:0] Q_BOOT      = 4'b1100;
    localparam logic [3:0] Q_PRECHARGE = 4'b1001;

    // Leg A is M1 over M3, leg B is M2 over M4.
    localparam int unsigned LEG_A_HI = 0;
    localparam int unsigned LEG_A_LO = 2;
    localparam int unsigned LEG_B_HI = 1;
    localparam int unsigned LEG_B_LO = 3;

    function automatic logic shoot_through(input logic [3:0] gates);
        return (gates[LEG_A_HI] & gates[LEG_A_LO]) | (gates[LEG_B_HI] & gates[LEG_B_LO]);
    endfunction

endpackage

// File: rtl/bridge_startup_sequencer_dwell_timer.sv
// Clearable dwell counter with a terminal-count compare; shared by the BOOT and
// PRECHARGE phases, which supply their own terminal value.
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count cycles spent in the current phase; clear has priority over count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/bridge_startup_sequencer.sv
// Cycle-exact start-up sequencer and shoot-through guard for the H-bridge gates.
// Optional macro BRIDGE_FAULT_COUNT_EN adds a saturating shoot-through event counter.
module bridge_startup_sequencer
    import bridge_pkg::*;
#(
    parameter int BOOT_CYCLES      = 1000,
    parameter int PRECHARGE_CYCLES = 1600,
    parameter int CNT_W            = 16
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_enable,
    input  logic [3:0] i_MOSFET,
    output logic [3:0] o_Q,
    output logic [2:0] o_state,
    output logic       o_ON,
    output logic       o_VG,
    output logic       o_fault,
    output logic [7:0] o_fault_cnt
);

    localparam logic [CNT_W-1:0] BOOT_TERM = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_TERM  = CNT_W'(PRECHARGE_CYCLES - 1);

    state_e           state_q;
    logic [3:0]       q_q;
    logic             on_q;
    logic             vg_q;
    logic             fault_q;
    logic             st_s;
    logic             done_s;
    logic             tmr_en_s;
    logic             tmr_clr_s;
    logic [CNT_W-1:0] term_s;

    assign st_s = shoot_through(i_MOSFET);

    // Dwell timer control: count only while staying in a timed phase.
    always_comb begin
        term_s   = BOOT_TERM;
        tmr_en_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                term_s   = BOOT_TERM;
                tmr_en_s = i_enable & ~done_s;
            end
            ST_PRECHARGE: begin
                term_s   = PRE_TERM;
                tmr_en_s = i_enable & ~done_s;
            end
            default: begin
                term_s   = BOOT_TERM;
                tmr_en_s = 1'b0;
            end
        endcase
        tmr_clr_s = ~tmr_en_s;
    end

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk_i  (i_clock),
        .rst_i  (i_RESET),
        .clr_i  (tmr_clr_s),
        .en_i   (tmr_en_s),
        .term_i (term_s),
        .done_o (done_s)
    );

    // Sequencer FSM; outputs are registered against the next state.
    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state_q <= ST_IDLE;
            q_q     <= Q_OFF;
            on_q    <= 1'b0;
            vg_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= ST_IDLE;
            q_q     <= Q_OFF;
            on_q    <= 1'b0;
            vg_q    <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_enable) begin
                        state_q <= ST_BOOT;
                        q_q     <= Q_BOOT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BOOT: begin
                    if (!i_enable) begin
                        state_q <= ST_IDLE;
                    end else if (done_s) begin
                        state_q <= ST_PRECHARGE;
                        q_q     <= Q_PRECHARGE;
                        on_q    <= 1'b1;
                    end else begin
                        state_q <= ST_BOOT;
                        q_q     <= Q_BOOT;
                    end
                end
                ST_PRECHARGE: begin
                    if (!i_enable) begin
                        state_q <= ST_IDLE;
                    end else if (done_s) begin
                        // First RUN pattern is sampled before the guard is active,
                        // so an illegal request is blanked rather than passed.
                        state_q <= ST_RUN;
                        q_q     <= st_s ? Q_OFF : i_MOSFET;
                        on_q    <= 1'b1;
                        vg_q    <= 1'b1;
                    end else begin
                        state_q <= ST_PRECHARGE;
                        q_q     <= Q_PRECHARGE;
                        on_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        state_q <= ST_IDLE;
                    end else if (st_s) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        q_q     <= i_MOSFET;
                        on_q    <= 1'b1;
                        vg_q    <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (!i_enable) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BRIDGE_FAULT_COUNT_EN
    logic [7:0] fault_cnt_q;

    // Saturating count of RUN cycles presenting a shoot-through request.
    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            fault_cnt_q <= 8'd0;
        end else if ((state_q == ST_RUN) && st_s && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end else begin
            fault_cnt_q <= fault_cnt_q;
        end
    end

    assign o_fault_cnt = fault_cnt_q;
`else
    assign o_fault_cnt = 8'd0;
`endif

    assign o_Q     = q_q;
    assign o_state = state_q;
    assign o_ON    = on_q;
    assign o_VG    = vg_q;
    assign o_fault = fault_q;

endmodule

// File: tb/tb_bridge_startup_sequencer.sv
// Self-checking bench: a vector table driven through a one-deep scoreboard on the
// default-parameter DUT, plus a fault/re-enable loop on a minimum-dwell instance.
module tb_bridge_startup_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BOOT  = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;
`ifdef BRIDGE_FAULT_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif
    localparam logic [7:0] F1 = FC_EN ? 8'd1 : 8'd0;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] q;
        logic       on;
        logic       vg;
        logic       flt;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [3:0] mos;
        int         n;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] mos;
    logic [3:0] m_q, f_q;
    logic [2:0] m_state, f_state;
    logic       m_on, m_vg, m_flt, f_on, f_vg, f_flt;
    logic [7:0] m_cnt, f_cnt;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    bridge_startup_sequencer dut (
        .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_MOSFET(mos),
        .o_Q(m_q), .o_state(m_state), .o_ON(m_on), .o_VG(m_vg),
        .o_fault(m_flt), .o_fault_cnt(m_cnt)
    );

    bridge_startup_sequencer #(
        .BOOT_CYCLES(1), .PRECHARGE_CYCLES(1), .CNT_W(16)
    ) dut_fast (
        .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_MOSFET(mos),
        .o_Q(f_q), .o_state(f_state), .o_ON(f_on), .o_VG(f_vg),
        .o_fault(f_flt), .o_fault_cnt(f_cnt)
    );

    function automatic exp_t mk(input logic [2:0] st, input logic [3:0] q, input logic on,
                                input logic vg, input logic flt, input logic [7:0] cnt);
        exp_t e;
        e.st = st; e.q = q; e.on = on; e.vg = vg; e.flt = flt; e.cnt = cnt;
        return e;
    endfunction

    function automatic void add(input string nm, input logic r, input logic e_en,
                                input logic [3:0] m, input int n, input exp_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e_en; v.mos = m; v.n = n; v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic step(input bit sel, input logic r, input logic e_en, input logic [3:0] m,
                        input exp_t e, input string nm);
        exp_t got;
        exp_t want;
        rst = r;
        en  = e_en;
        mos = m;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        want = sb_q.pop_front();
        if (sel) got = exp_t'({f_state, f_q, f_on, f_vg, f_flt, f_cnt});
        else     got = exp_t'({m_state, m_q, m_on, m_vg, m_flt, m_cnt});
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got st=%0d q=%b on=%b vg=%b flt=%b cnt=%0d, want st=%0d q=%b on=%b vg=%b flt=%b cnt=%0d",
                     nm, got.st, got.q, got.on, got.vg, got.flt, got.cnt,
                     want.st, want.q, want.on, want.vg, want.flt, want.cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        mos = 4'b0000;

        add("reset",        1'b1, 1'b0, 4'b0000,    3, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
        add("idle_hold",    1'b0, 1'b0, 4'b0000,    2, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
        add("idle_st",      1'b0, 1'b0, 4'b0101,    2, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
        add("boot",         1'b0, 1'b1, 4'b0000, 1000, mk(S_BOOT,  4'b1100, 1'b0, 1'b0, 1'b0, 8'd0));
        add("precharge",    1'b0, 1'b1, 4'b0000, 1600, mk(S_PRE,   4'b1001, 1'b1, 1'b0, 1'b0, 8'd0));
        add("run_entry",    1'b0, 1'b1, 4'b0001,    1, mk(S_RUN,   4'b0001, 1'b1, 1'b1, 1'b0, 8'd0));
        add("run_0010",     1'b0, 1'b1, 4'b0010,    1, mk(S_RUN,   4'b0010, 1'b1, 1'b1, 1'b0, 8'd0));
        add("run_1000",     1'b0, 1'b1, 4'b1000,    1, mk(S_RUN,   4'b1000, 1'b1, 1'b1, 1'b0, 8'd0));
        add("run_0110",     1'b0, 1'b1, 4'b0110,    1, mk(S_RUN,   4'b0110, 1'b1, 1'b1, 1'b0, 8'd0));
        add("run_1001",     1'b0, 1'b1, 4'b1001,    1, mk(S_RUN,   4'b1001, 1'b1, 1'b1, 1'b0, 8'd0));
        add("run_0011",     1'b0, 1'b1, 4'b0011,    1, mk(S_RUN,   4'b0011, 1'b1, 1'b1, 1'b0, 8'd0));
        add("run_1100",     1'b0, 1'b1, 4'b1100,    1, mk(S_RUN,   4'b1100, 1'b1, 1'b1, 1'b0, 8'd0));
        add("st_0101",      1'b0, 1'b1, 4'b0101,    1, mk(S_FAULT, 4'b0000, 1'b0, 1'b0, 1'b1, F1));
        add("fault_hold",   1'b0, 1'b1, 4'b0000,  500, mk(S_FAULT, 4'b0000, 1'b0, 1'b0, 1'b1, F1));
        add("fault_st",     1'b0, 1'b1, 4'b1010,    3, mk(S_FAULT, 4'b0000, 1'b0, 1'b0, 1'b1, F1));
        add("fault_exit",   1'b0, 1'b0, 4'b0000,    1, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, F1));
        add("boot_part",    1'b0, 1'b1, 4'b0000,  500, mk(S_BOOT,  4'b1100, 1'b0, 1'b0, 1'b0, F1));
        add("boot_abort",   1'b0, 1'b0, 4'b0000,   10, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, F1));
        add("boot_restart", 1'b0, 1'b1, 4'b0000, 1000, mk(S_BOOT,  4'b1100, 1'b0, 1'b0, 1'b0, F1));
        add("boot_done",    1'b0, 1'b1, 4'b0000,  100, mk(S_PRE,   4'b1001, 1'b1, 1'b0, 1'b0, F1));
        add("reset_pre",    1'b1, 1'b1, 4'b0000,    1, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
        add("boot_post_rst",1'b0, 1'b1, 4'b0000, 1000, mk(S_BOOT,  4'b1100, 1'b0, 1'b0, 1'b0, 8'd0));
        add("pre_post_rst", 1'b0, 1'b1, 4'b0000, 1600, mk(S_PRE,   4'b1001, 1'b1, 1'b0, 1'b0, 8'd0));
        add("run_post_rst", 1'b0, 1'b1, 4'b0110,    5, mk(S_RUN,   4'b0110, 1'b1, 1'b1, 1'b0, 8'd0));
        add("dis_and_st",   1'b0, 1'b0, 4'b1010,    1, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, F1));
        add("boot5",        1'b0, 1'b1, 4'b0000, 1000, mk(S_BOOT,  4'b1100, 1'b0, 1'b0, 1'b0, F1));
        add("pre5",         1'b0, 1'b1, 4'b0000, 1600, mk(S_PRE,   4'b1001, 1'b1, 1'b0, 1'b0, F1));
        add("pre_term_dis", 1'b0, 1'b0, 4'b0000,    2, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, F1));

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(1'b0, tbl[i].rst, tbl[i].en, tbl[i].mos, tbl[i].e, tbl[i].name);
            end
        end

        // Minimum-dwell instance: repeated fault/re-enable drives the counter to saturation.
        step(1'b1, 1'b1, 1'b0, 4'b0000, mk(S_IDLE, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0), "f_reset");
        for (int k = 1; k <= 300; k++) begin
            logic [7:0] prev_c;
            logic [7:0] now_c;
            prev_c = FC_EN ? ((k - 1 > 255) ? 8'd255 : 8'(k - 1)) : 8'd0;
            now_c  = FC_EN ? ((k > 255) ? 8'd255 : 8'(k)) : 8'd0;
            step(1'b1, 1'b0, 1'b1, 4'b0000, mk(S_BOOT,  4'b1100, 1'b0, 1'b0, 1'b0, prev_c), "f_boot");
            step(1'b1, 1'b0, 1'b1, 4'b0000, mk(S_PRE,   4'b1001, 1'b1, 1'b0, 1'b0, prev_c), "f_pre");
            step(1'b1, 1'b0, 1'b1, 4'b0011, mk(S_RUN,   4'b0011, 1'b1, 1'b1, 1'b0, prev_c), "f_run");
            step(1'b1, 1'b0, 1'b1, 4'b0101, mk(S_FAULT, 4'b0000, 1'b0, 1'b0, 1'b1, now_c),  "f_st");
            step(1'b1, 1'b0, 1'b0, 4'b0000, mk(S_IDLE,  4'b0000, 1'b0, 1'b0, 1'b0, now_c),  "f_exit");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
